// File: rtl/chunked_logic_unit.sv
// Chunked bitwise logic unit: applies AND/OR/XOR/NOR to captured operands
// one CHUNK-wide slice per clock, LSB slice first, then pulses done.
module chunked_logic_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             zero
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              zero_q, zero_d;

  function automatic logic [CHUNK-1:0] chunk_op(
    input logic [1:0]       o,
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y
  );
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  // Next-state logic: accept requests in IDLE/DONE, process one slice per cycle in RUN.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    idx_d   = idx_q;
    res_d   = res_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          op_d    = op;
          idx_d   = '0;
          res_d   = '0;
          zero_d  = 1'b0;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Constant-slice decode of the running index keeps the part-select static.
        for (int unsigned i = 0; i < N; i++) begin
          if (idx_q == IDXW'(i)) begin
            res_d[i*CHUNK +: CHUNK] = chunk_op(op_q, a_q[i*CHUNK +: CHUNK], b_q[i*CHUNK +: CHUNK]);
          end
        end
        if (idx_q == IDXW'(N - 1)) begin
          state_d = S_DONE;
          idx_d   = '0;
          zero_d  = (res_d == '0);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign res  = res_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_chunked_logic_unit.sv
// Self-checking bench: two instances (CHUNK=8 and CHUNK=32) share stimulus
// and are compared every cycle against a whole-word masked-result model.
module tb_chunked_logic_unit;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy0, done0, zero0, busy1, done1, zero1;
  logic [31:0] res0, res1;

  always #5 clk = ~clk;

  chunked_logic_unit #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy0), .done(done0), .res(res0), .zero(zero0)
  );

  chunked_logic_unit #(.WIDTH(32), .CHUNK(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy1), .done(done1), .res(res1), .zero(zero1)
  );

  int checks = 0;
  int errors = 0;

  // Model: k = edges since the accepting edge (-1 when idle); result after k
  // edges is the whole-word result masked to the low k chunks.
  int          nch [2] = '{4, 1};
  int          cbit[2] = '{8, 32};
  int          k   [2] = '{-1, -1};
  logic [31:0] ma  [2], mb[2], mres[2];
  logic [1:0]  mop [2];
  logic        mzero[2];
  logic        armed = 1'b0;

  function automatic logic [31:0] full_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  function automatic logic [31:0] low_mask(input int bits);
    if (bits >= 32) return 32'hFFFF_FFFF;
    return (32'h1 << bits) - 32'h1;
  endfunction

  function automatic logic m_busy(input int d);
    return (k[d] >= 0) && (k[d] < nch[d]);
  endfunction

  function automatic logic m_done(input int d);
    return k[d] == nch[d];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model advance at each rising edge.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int          nk;
      logic [31:0] nres;
      logic        nz;
      nk = k[d]; nres = mres[d]; nz = mzero[d];
      if (!rst_n) begin
        nk = -1; nres = '0; nz = 1'b0;
        armed <= 1'b1;
      end else if (start && !m_busy(d)) begin
        ma[d] <= a; mb[d] <= b; mop[d] <= op;
        nk = 0; nres = '0; nz = 1'b0;
      end else if (m_busy(d)) begin
        nk = k[d] + 1;
        nres = full_op(mop[d], ma[d], mb[d]) & low_mask(nk * cbit[d]);
        if (nk == nch[d]) nz = (nres == 32'h0);
      end else if (m_done(d)) begin
        nk = -1;
      end
      k[d]     <= nk;
      mres[d]  <= nres;
      mzero[d] <= nz;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("busy0", 32'(busy0), 32'(m_busy(0)));
      chk("done0", 32'(done0), 32'(m_done(0)));
      chk("res0",  res0,       mres[0]);
      chk("zero0", 32'(zero0), 32'(mzero[0]));
      chk("busy1", 32'(busy1), 32'(m_busy(1)));
      chk("done1", 32'(done1), 32'(m_done(1)));
      chk("res1",  res1,       mres[1]);
      chk("zero1", 32'(zero1), 32'(mzero[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Waits (bounded) for done0, counting busy cycles seen before it.
  task automatic wait_done0(output logic ok, output int busy_cnt);
    ok = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done0 === 1'b1) begin
        ok = 1'b1;
        return;
      end
      if (busy0 === 1'b1) busy_cnt++;
    end
  endtask

  task automatic run_lit(input string nm, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [1:0] iop, input logic [31:0] er, input logic ez);
    logic ok;
    int   bc;
    a = ia; b = ib; op = iop; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done0(ok, bc);
    chk({nm, "_done_seen"}, 32'(ok), 32'd1);
    chk({nm, "_busy_cycles"}, 32'(bc), 32'd4);
    chk({nm, "_res"}, res0, er);
    chk({nm, "_zero"}, 32'(zero0), 32'(ez));
    tick();
  endtask

  initial begin
    logic        ok;
    int          bc, dn;
    logic [31:0] seen;

    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    tick();
    start = 1'b1;  // reset must win over start
    tick();
    @(negedge clk);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_res",  res0,       32'h0);
    chk("rst_zero", 32'(zero0), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();

    run_lit("and1", 32'h0000_0039, 32'h0000_0003, 2'b00, 32'h0000_0001, 1'b0);
    run_lit("and0", 32'h0000_0002, 32'h0000_0001, 2'b00, 32'h0000_0000, 1'b1);
    run_lit("or",   32'hF0F0_F0F0, 32'hFF00_FF00, 2'b01, 32'hFFF0_FFF0, 1'b0);
    run_lit("xor",  32'hF0F0_F0F0, 32'hFF00_FF00, 2'b10, 32'h0FF0_0FF0, 1'b0);
    run_lit("nor",  32'hF0F0_F0F0, 32'hFF00_FF00, 2'b11, 32'h000F_000F, 1'b0);

    // Start during busy with changed operand is ignored.
    a = 32'hFFFF_FFFF; b = 32'h0000_FFFF; op = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 32'h0; start = 1'b1;
    tick();
    start = 1'b0;
    dn = 0; seen = 32'hDEAD_BEEF;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done0 === 1'b1) begin dn++; seen = res0; end
    end
    chk("ign_done_pulses", 32'(dn), 32'd1);
    chk("ign_res", seen, 32'h0000_FFFF);
    tick();

    // Reset one edge after chunk 2 is written aborts the operation.
    a = 32'h1234_5678; b = 32'hFFFF_FFFF; op = 2'b01; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    chk("abort_res",  res0,       32'h0);
    chk("abort_zero", 32'(zero0), 32'd0);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done0 === 1'b1) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    tick();

    // Back-to-back: new start accepted in the done cycle.
    a = 32'h1234_5678; b = 32'h0F0F_0F0F; op = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done0(ok, bc);
    chk("b2b_first_done", 32'(ok), 32'd1);
    chk("b2b_first_res", res0, 32'h1D3B_5977);
    a = 32'hAAAA_5555; b = 32'h0000_FFFF; op = 2'b01; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("b2b_busy_next", 32'(busy0), 32'd1);
    wait_done0(ok, bc);
    chk("b2b_second_done", 32'(ok), 32'd1);
    chk("b2b_second_res", res0, 32'hAAAA_FFFF);
    chk("b2b_second_zero", 32'(zero0), 32'd0);
    tick();
    tick();

    // Single-chunk instance: done one cycle after busy.
    a = 32'hF0F0_F0F0; b = 32'hFF00_FF00; op = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("n1_busy", 32'(busy1), 32'd1);
    chk("n1_done_early", 32'(done1), 32'd0);
    @(negedge clk);
    chk("n1_busy_off", 32'(busy1), 32'd0);
    chk("n1_done", 32'(done1), 32'd1);
    chk("n1_res", res1, 32'h0FF0_0FF0);
    tick();
    repeat (6) tick();

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      start = ($urandom_range(0, 2) == 0);
      a     = $urandom;
      b     = $urandom;
      op    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) begin
        b  = a;
        op = 2'b10;
      end
      tick();
    end
    rst_n = 1'b1; start = 1'b0;
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
